// File: rtl/spi_sdcard_target.sv
// spi_sdcard_target: SPI-mode (mode 0) SD card model, card side.
// It receives 48-bit command frames on MOSI, checks their CRC7 and offers
// each command to a host-side controller. Host-supplied bytes are streamed
// on MISO, and a CRC16 runs over every host byte that is transmitted.
//
// Ports:
//   clk, reset            system clock (>= 4x SCK), synchronous active-high reset
//   spi_cs_n/sck/mosi     SPI inputs from the master (asynchronous, synchronised here)
//   spi_miso              data to the master
//   cmd_valid/cmd_ready   command handshake; cmd_index, cmd_arg, cmd_crc_ok stay stable while held
//   rx_data/rx_strobe     last byte received on MOSI, plus a one-cycle update pulse
//   tx_data/tx_valid      next host byte for MISO; tx_ready pulses when it is taken
//   crc16/crc16_clr       running CRC16 over transmitted host bits, and its clear
module spi_sdcard_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'hff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [0:5]  cmd_index,
  output logic [0:31] cmd_arg,
  output logic        cmd_crc_ok,
  output logic [0:7]  rx_data,
  output logic        rx_strobe,
  input  logic [0:7]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [0:15] crc16,
  input  logic        crc16_clr
);

  typedef enum logic [1:0] {IDLE, HUNT, CMD, PEND} state_t;

  // Serial CRC7 (x^7+x^3+1) over one byte, MSB (bit [0]) first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] c_in, input logic [0:7] b);
    logic [6:0] c;
    logic       fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[6] ^ b[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Input synchronisers. The CS chain resets to "asserted" and cs_low_prev
  // to 1, so a CS held low across reset is never mistaken for a fresh
  // assertion: framing only restarts at a real CS falling edge.
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic cs_low_prev, sck_prev, framed;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync     <= '0;
      sck_sync    <= '0;
      mosi_sync   <= '0;
      cs_low_prev <= 1'b1;
      sck_prev    <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_low_prev <= ~cs_sync[SYNC_STAGES-1];
      sck_prev    <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic cs_low, sck_s, mosi_s, cs_assert, sck_rise, sck_fall;
  assign cs_low    = ~cs_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_assert = cs_low & ~cs_low_prev;
  assign sck_rise  = framed & sck_s & ~sck_prev;
  assign sck_fall  = framed & ~sck_s & sck_prev;

  // framed: a transfer that started with a seen CS assertion is in progress.
  always_ff @(posedge clk) begin
    if (reset)          framed <= 1'b0;
    else if (!cs_low)   framed <= 1'b0;
    else if (cs_assert) framed <= 1'b1;
  end

  // Receive side: byte assembly on rising edges.
  logic [2:0] bit_cnt;
  logic [0:6] rx_shift;
  logic       byte_done;  // last rising edge completed a byte; next fall reloads MISO

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= '0;
      rx_data   <= 8'h00;
      rx_strobe <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      if (!framed) begin
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[1:6], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data   <= {rx_shift, mosi_s};
            rx_strobe <= 1'b1;
            byte_done <= 1'b1;
          end
        end
        if (sck_fall) byte_done <= 1'b0;
      end
    end
  end

  // Transmit side. host_mask tracks which bits in tx_shift came from the
  // host, so fill bits never enter the CRC16.
  logic [0:7] tx_shift, host_mask;
  logic       load_now;
  logic [15:0] crc16_reg;
  assign load_now = cs_assert | (sck_fall & byte_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift  <= FILL_BYTE;
      host_mask <= '0;
      tx_ready  <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (load_now) begin
        if (tx_valid) begin
          tx_shift  <= tx_data;
          host_mask <= 8'hff;
          tx_ready  <= 1'b1;
        end else begin
          tx_shift  <= FILL_BYTE;
          host_mask <= 8'h00;
        end
      end else if (sck_fall) begin
        tx_shift  <= {tx_shift[1:7], 1'b1};
        host_mask <= {host_mask[1:7], 1'b0};
      end
    end
  end

  // Every falling edge (shift or reload) retires the bit at tx_shift[0].
  always_ff @(posedge clk) begin
    if (reset || crc16_clr)
      crc16_reg <= 16'h0000;
    else if (sck_fall && host_mask[0])
      crc16_reg <= {crc16_reg[14:0], 1'b0} ^
                   ({16{crc16_reg[15] ^ tx_shift[0]}} & 16'h1021);
  end

  assign crc16    = crc16_reg;
  assign spi_miso = framed ? tx_shift[0] : 1'b1;

  // Command framing FSM. It works from the registered rx_data/rx_strobe.
  state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  logic [2:0] byte_cnt;
  logic [6:0] crc7_reg;
  logic [5:0] frame_idx;
  logic [31:0] arg_shift;
  logic       start_byte, last_byte;
  assign start_byte = (state_reg == HUNT) && framed && rx_strobe && (rx_data[0:1] == 2'b01);
  assign last_byte  = (state_reg == CMD) && framed && rx_strobe && (byte_cnt == 3'd5);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cs_assert) state_next = HUNT;
      HUNT: begin
        if (!framed)         state_next = IDLE;
        else if (start_byte) state_next = CMD;
      end
      CMD: begin
        if (!framed)        state_next = IDLE;
        else if (last_byte) state_next = PEND;
      end
      PEND: if (cmd_ready) state_next = framed ? HUNT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_valid = (state_reg == PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= 3'd0;
      crc7_reg   <= 7'd0;
      frame_idx  <= 6'd0;
      arg_shift  <= 32'd0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'd0;
      cmd_crc_ok <= 1'b0;
    end else if (start_byte) begin
      frame_idx <= rx_data[2:7];
      crc7_reg  <= crc7_byte(7'd0, rx_data);
      byte_cnt  <= 3'd1;
    end else if (last_byte) begin
      cmd_index  <= frame_idx;
      cmd_arg    <= arg_shift;
      cmd_crc_ok <= (crc7_reg == rx_data[0:6]) && rx_data[7];
    end else if ((state_reg == CMD) && framed && rx_strobe) begin
      arg_shift <= {arg_shift[23:0], rx_data};
      crc7_reg  <= crc7_byte(crc7_reg, rx_data);
      byte_cnt  <= byte_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_spi_sdcard_target.sv
// tb_spi_sdcard_target: directed bench for spi_sdcard_target. The main
// process plays SPI master and host; expected commands, MOSI bytes and MISO
// bytes are queued when issued and checked by independent monitors.
module tb_spi_sdcard_target;
  localparam int HALF = 5;  // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset, spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic        cmd_valid, cmd_ready, cmd_crc_ok, rx_strobe, tx_valid, tx_ready, crc16_clr;
  logic [0:5]  cmd_index;
  logic [0:31] cmd_arg;
  logic [0:7]  rx_data, tx_data;
  logic [0:15] crc16;

  spi_sdcard_target dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_crc_ok(cmd_crc_ok), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .crc16(crc16), .crc16_clr(crc16_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        ok;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] tx_q[$];
  int total = 0;
  int bad = 0;
  int tx_ready_cnt = 0;
  int cmd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_on();
    spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_off();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic xfer(input logic [7:0] m, input logic [7:0] exp_miso);
    rx_q.push_back(m);
    miso_q.push_back(exp_miso);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = m[i];
      tick(HALF);
      spi_sck = 1'b1;
      tick(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) xfer(f[47-8*i -: 8], 8'hff);
  endtask

  task automatic wait_cmds();
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || cmd_valid) && n < 300) begin
      tick(1);
      n++;
    end
    check("cmd_wait_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_index"}, 32'(cmd_index), 32'd0);
    check({tag, "_cmd_arg"}, 32'(cmd_arg), 32'd0);
    check({tag, "_cmd_crc_ok"}, 32'(cmd_crc_ok), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_strobe"}, 32'(rx_strobe), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    check({tag, "_crc16"}, 32'(crc16), 32'd0);
    check({tag, "_miso"}, 32'(spi_miso), 32'd1);
  endtask

  // Host transmit feeder: presents the head of tx_q, pops it on tx_ready.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_ready) begin
        tx_ready_cnt++;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      if (tx_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = tx_q[0];
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  // MISO monitor: assembles bytes at the master's sampling edge.
  initial begin
    logic [7:0] sh;
    int n;
    sh = 8'h00;
    n = 0;
    forever begin
      @(posedge spi_sck or posedge spi_cs_n);
      if (spi_cs_n) n = 0;
      else begin
        sh = {sh[6:0], spi_miso};
        n++;
        if (n == 8) begin
          n = 0;
          if (miso_q.size() == 0) check("miso_unexpected_byte", 32'(sh), 32'hdead);
          else check("miso_byte", 32'(sh), 32'(miso_q.pop_front()));
        end
      end
    end
  end

  // rx_data monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_strobe) begin
        if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hdead);
        else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
  end

  // Command monitor: compares, verifies the hold, then accepts.
  initial begin
    cmd_t e;
    cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        cmd_seen++;
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 32'(cmd_index), 32'hdead);
        end else begin
          e = cmd_q.pop_front();
          check("cmd_index", 32'(cmd_index), 32'(e.idx));
          check("cmd_arg", 32'(cmd_arg), e.arg);
          check("cmd_crc_ok", 32'(cmd_crc_ok), 32'(e.ok));
          repeat (3) begin
            @(negedge clk);
            check("cmd_hold_valid", 32'(cmd_valid), 32'd1);
            check("cmd_hold_arg", 32'(cmd_arg), e.arg);
            check("cmd_hold_index", 32'(cmd_index), 32'(e.idx));
          end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("cmd_release", 32'(cmd_valid), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; crc16_clr = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    check_reset_outputs("por");

    // CMD0
    cmd_q.push_back(cmd_t'{6'd0, 32'h0000_0000, 1'b1});
    cs_on();
    frame(48'h40_00000000_95);
    cs_off();
    wait_cmds();

    // Host byte presented during the first byte, then nothing
    cs_on();
    tx_q.push_back(8'h01);
    base = tx_ready_cnt;
    xfer(8'hff, 8'hff);
    xfer(8'hff, 8'h01);
    xfer(8'hff, 8'hff);
    cs_off();
    check("tx_ready_pulses", 32'(tx_ready_cnt - base), 32'd1);

    // CRC16 over 512 x FF, then the CRC bytes themselves
    crc16_clr = 1'b1;
    tick(1);
    crc16_clr = 1'b0;
    check("crc16_clear", 32'(crc16), 32'd0);
    for (int i = 0; i < 512; i++) tx_q.push_back(8'hff);
    tx_q.push_back(8'h7f);
    tx_q.push_back(8'ha1);
    tick(2);
    cs_on();
    for (int i = 0; i < 512; i++) xfer(8'hff, 8'hff);
    tick(4);
    check("crc16_512ff", 32'(crc16), 32'h7fa1);
    xfer(8'hff, 8'h7f);
    xfer(8'hff, 8'ha1);
    cs_off();
    check("crc16_residue", 32'(crc16), 32'd0);

    // Aborted frame, then a full CMD0
    base = cmd_seen;
    cs_on();
    xfer(8'h40, 8'hff);
    xfer(8'h00, 8'hff);
    xfer(8'h00, 8'hff);
    cs_off();
    tick(20);
    check("abort_no_cmd", 32'(cmd_seen - base), 32'd0);
    cmd_q.push_back(cmd_t'{6'd0, 32'h0000_0000, 1'b1});
    cs_on();
    frame(48'h40_00000000_95);
    cs_off();
    wait_cmds();

    // CMD8 after fill bytes, good and bad CRC
    cmd_q.push_back(cmd_t'{6'd8, 32'h0000_01aa, 1'b1});
    cs_on();
    xfer(8'hff, 8'hff);
    xfer(8'hff, 8'hff);
    frame(48'h48_000001aa_87);
    cs_off();
    wait_cmds();
    cmd_q.push_back(cmd_t'{6'd8, 32'h0000_01aa, 1'b0});
    cs_on();
    xfer(8'hff, 8'hff);
    xfer(8'hff, 8'hff);
    frame(48'h48_000001aa_86);
    cs_off();
    wait_cmds();

    // Reset in the middle of frame byte 4
    tx_q.push_back(8'h5a);
    tick(2);
    cs_on();
    xfer(8'h48, 8'h5a);
    xfer(8'h00, 8'hff);
    xfer(8'h00, 8'hff);
    xfer(8'h01, 8'hff);
    for (int i = 7; i >= 4; i--) begin
      spi_mosi = 1'(i % 2);
      tick(HALF);
      spi_sck = 1'b1;
      tick(HALF);
      spi_sck = 1'b0;
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    cs_off();
    cmd_q.push_back(cmd_t'{6'd8, 32'h0000_01aa, 1'b1});
    cs_on();
    frame(48'h48_000001aa_87);
    cs_off();
    wait_cmds();

    tick(20);
    check("cmd_q_left", 32'(cmd_q.size()), 32'd0);
    check("rx_q_left", 32'(rx_q.size()), 32'd0);
    check("miso_q_left", 32'(miso_q.size()), 32'd0);
    check("cmd_count", 32'(cmd_seen), 32'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_sdcard_target.md
Name: spi_sdcard_target

Overview:
SPI-mode SD card target (card side) used as an in-fabric SD card model. It can be driven by the existing SD card MMIO master for loopback testing, or it can serve an external SPI host. It frames 48-bit commands, checks their CRC7 and hands each command to a host-side controller over a valid/ready handshake. It streams host-supplied response and data bytes on MISO and keeps a running CRC16 over the bytes it transmits.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on spi_cs_n, spi_sck and spi_mosi; legal range 2..4.
FILL_BYTE, 8'hff, byte driven on MISO when no host byte is available at a byte boundary.

Ports:
clk  in  1  system clock; must be at least 4x the SCK frequency.
reset  in  1  synchronous, active-high.
spi_cs_n  in  1  chip select, active low.
spi_sck  in  1  SPI clock, mode 0.
spi_mosi  in  1  data from the SPI master.
spi_miso  out  1  data to the SPI master.
cmd_valid  out  1  a complete command frame is held.
cmd_ready  in  1  host accepts the held command.
cmd_index  out  [0:5]  command index (frame byte 0, bits [2:7]).
cmd_arg  out  [0:31]  command argument (frame bytes 1..4).
cmd_crc_ok  out  1  received CRC7 matched and the end bit was 1.
rx_data  out  [0:7]  last complete byte received on MOSI.
rx_strobe  out  1  one-cycle pulse when rx_data updates.
tx_data  in  [0:7]  next byte to transmit.
tx_valid  in  1  tx_data is available.
tx_ready  out  1  one-cycle pulse when tx_data is consumed.
crc16  out  [0:15]  running CRC16 (polynomial x^16+x^12+x^5+1) over transmitted host bytes.
crc16_clr  in  1  clears crc16 to 16'h0000.

Behaviour:
- Synchronisation: all three SPI inputs pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised SCK. All internal timing refers to the synchronised signals.
- Bit order: MSB first; bit [0] of every byte is sent or received first.
- Sampling: MOSI is sampled on SCK rising edges. A bit counter runs 0..7 and wraps. On wrap, rx_data gets the assembled byte and rx_strobe pulses.
- MISO update: the MISO shift register shifts on SCK falling edges. spi_miso = shift_reg[0].
- MISO byte loading: on the falling edge that follows bit 7, and at the cycle CS is seen asserted:
  - if tx_valid is high: load tx_data and pulse tx_ready;
  - otherwise: load FILL_BYTE.
- CRC16 updates per bit, only for host-loaded bits, on the falling edge as each bit is shifted out.
- crc16_clr has priority over an update in the same cycle.
- CS deasserted:
  - spi_miso = 1 and the bit counter is held at 0;
  - CS assertion realigns byte framing.
- Command state machine:
  - IDLE: CS deasserted. Go to HUNT when CS is asserted.
  - HUNT: on each received byte with bits [0:1] = 2'b01, store it as frame byte 0, clear CRC7 and go to CMD. Other bytes are ignored.
  - CMD: collect frame bytes 1..5.
    - CRC7 (x^7+x^3+1, init 0) runs over bits 0..39.
    - After byte 5: cmd_crc_ok = (crc7 == byte5[0:6]) && byte5[7].
    - Latch cmd_index and cmd_arg, assert cmd_valid, go to PEND.
  - PEND: cmd_valid is held, with its outputs stable, until a cycle where cmd_valid && cmd_ready. Then return to HUNT (or to IDLE if CS is deasserted). Bytes received while in PEND are not framed but still appear on rx_data.
- CS deassert in CMD discards the partial frame and goes to IDLE; cmd_valid stays low.
- CS deassert in PEND keeps cmd_valid held until it is accepted.
- tx_valid must stay high until tx_ready. tx_ready is never asserted while CS is deasserted.
- Reset values:
  - state IDLE;
  - cmd_valid 0, cmd_index 0, cmd_arg 0, cmd_crc_ok 0;
  - rx_data 8'h00, rx_strobe 0;
  - tx_ready 0;
  - crc16 16'h0000;
  - MISO shift register FILL_BYTE, so spi_miso = 1.
- Reset mid-transfer aborts immediately. Framing resumes only at the next CS assertion.

Test Plan:
1. CMD0 frame 40 00 00 00 00 95 -> cmd_valid with cmd_index 0, cmd_arg 32'h00000000, cmd_crc_ok 1. Outputs hold until cmd_ready.
2. CMD8 frame preceded by two FF bytes: 48 00 00 01 AA 87 -> cmd_index 8, cmd_arg 32'h000001AA, cmd_crc_ok 1. Repeat with last byte 86 -> cmd_crc_ok 0.
3. Host presents tx_data 8'h01 before the second byte boundary -> master reads FF then 01; tx_ready pulses exactly once. With tx_valid low -> master reads FF.
4. crc16_clr, then stream 512 bytes of 8'hFF -> crc16 = 16'h7FA1. Then stream 8'h7F, 8'hA1 and master reads them back in order.
5. Deassert CS after the third byte of a frame -> no cmd_valid. A new full CMD0 after re-assert decodes correctly.
6. Assert reset during byte 4 of a frame -> all outputs return to reset values and spi_miso = 1. The next frame decodes normally.
